adder_inv_pipe: RTL
===================

// Module: adder_inv_pipe
// PURPOSE
//  Inverse of the registered adder: given a BITWIDTH+1-bit sum and one BITWIDTH-bit addend,
//  recovers the other addend (oData = iSum - iData0) through a 2-stage pipelined subtractor
//  with valid/ready handshake on both sides. Sits downstream of adder_reg in checker and
//  decode datapaths; flags results that are not a valid BITWIDTH-bit addend.
// PARAMETERS
//  BITWIDTH  32  addend width; iSum is BITWIDTH+1; must be even and >= 2
//  LOW_W     BITWIDTH/2  width of stage-1 low slice; stage 2 handles the remaining BITWIDTH+1-LOW_W bits
// PORTS
//  iClk        in   1           clock, rising edge
//  iRstN       in   1           reset, asynchronous, active-low
//  iClr        in   1           synchronous clear of the pipeline (valids and data to 0)
//  iValid      in   1           input beat valid
//  oReady      out  1           block can accept an input beat this cycle
//  iSum        in   BITWIDTH+1  sum operand
//  iData0      in   BITWIDTH    known addend
//  oValid      out  1           output beat valid
//  iReady      in   1           downstream accepts the output beat
//  oData       out  BITWIDTH    recovered addend, iSum - iData0, low BITWIDTH bits
//  oUnderflow  out  1           iSum < iData0 (borrow out of the top bit)
//  oOverflow   out  1           no underflow and bit BITWIDTH of the difference is 1
// BEHAVIOUR
//  - Reset: all stage valids 0; oValid, oData, oUnderflow, oOverflow = 0; oReady = 1 one cycle after release.
//  - Input accepted when iValid & oReady at a rising edge; output consumed when oValid & iReady.
//  - Stage 1 (s1): registers diff_lo = iSum[LOW_W-1:0] - iData0[LOW_W-1:0] and borrow_lo;
//    registers the upper slices of iSum and iData0 unchanged.
//  - Stage 2 (s2): diff_hi = sum_hi - {1'b0, data0_hi} - borrow_lo; the result has BITWIDTH+1-LOW_W bits
//    plus borrow_hi. Registers oData = {diff_hi[BITWIDTH-LOW_W-1:0], diff_lo};
//    oOverflow = ~borrow_hi & diff_hi[BITWIDTH-LOW_W]; oUnderflow = borrow_hi.
//  - Latency: 2 cycles from input acceptance to oValid. Throughput: 1 beat/cycle while iReady = 1.
//  - Stall: s2 holds when oValid & ~iReady; s1 advances into s2 only if s2 is empty or draining;
//    oReady = ~s1_valid | s1_advances (combinational from iReady; no bubbles under continuous flow).
//  - Output registers are stable while oValid & ~iReady; data and flags never change during a stall.
//  - Flags are exclusive; oUnderflow and oOverflow are meaningful only while oValid = 1.
//  - iClr: at the next edge, both valids go to 0 and the data and flag registers go to 0. An input
//    presented in the same cycle is dropped. iClr has priority over accept and advance.
//  - Async reset mid-stream: in-flight beats are discarded; no output beat appears for them.
//  - Wrap-around: the difference is computed modulo 2^(BITWIDTH+1) before flag decode. Max case:
//    iSum = all-ones (BITWIDTH+1 bits), iData0 = 0 -> oOverflow = 1, oData = all-ones.
// CONFIGURATION
//  ADDER_INV_SATURATE_EN defined: on oUnderflow, oData = 0; on oOverflow, oData = {BITWIDTH{1'b1}}.
//    The flags are still reported.
//  Not defined: oData is always the raw low BITWIDTH bits of the modular difference.
// TESTING
//  1. Reset held 200 ns with iValid = 1 -> oValid = 0, oData = 0 and no beats accepted. After
//     release, iSum = 'd300, iData0 = 'd100 -> two cycles later oValid = 1, oData = 'd200, both flags 0.
//  2. 100 random beats (random iData0 and iData1, iSum = iData0 + iData1, iReady = 1) ->
//     each oData equals the delayed iData1, beats arrive in order, 1 per cycle, flags 0.
//  3. Backpressure: iReady = 0 for 5 cycles mid-stream -> oData is stable, oReady drops after 2 beats
//     are buffered, and no beat is lost or duplicated after iReady returns to 1.
//  4. iSum = 'd5, iData0 = 'd7 -> oUnderflow = 1. oData = 32'hFFFF_FFFE raw, or 0 with the macro defined.
//  5. iSum = 33'h1_0000_0005, iData0 = 'd2 -> oOverflow = 1. oData = 'd3 raw, or 32'hFFFF_FFFF
//     with the macro defined.
//  6. iClr pulsed with 2 beats in flight and iValid = 1 -> the next cycle oValid = 0, and those
//     2 beats and the same-cycle input never appear at the output.

Source files
------------

// File: rtl/adder_inv_pipe.sv
// Recovers the unknown addend (iSum - iData0) in a 2-stage split subtractor; valid/ready on both sides, 2-cycle latency.
// Stalls hold the output registers; define ADDER_INV_SATURATE_EN to clamp oData on underflow/overflow.
module adder_inv_pipe #(
  parameter int BITWIDTH = 32,
  parameter int LOW_W    = BITWIDTH / 2
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iClr,
  input  logic                iValid,
  output logic                oReady,
  input  logic [BITWIDTH:0]   iSum,
  input  logic [BITWIDTH-1:0] iData0,
  output logic                oValid,
  input  logic                iReady,
  output logic [BITWIDTH-1:0] oData,
  output logic                oUnderflow,
  output logic                oOverflow
);

  localparam int HI_W = BITWIDTH + 1 - LOW_W;

  logic                rst_done;
  logic                s1_valid;
  logic                borrow_lo;
  logic [LOW_W-1:0]    diff_lo;
  logic [HI_W-1:0]     sum_hi;
  logic [HI_W-2:0]     data0_hi;

  logic [LOW_W:0]      lo_full;
  logic [HI_W:0]       hi_full;
  logic                borrow_hi;
  logic [HI_W-1:0]     diff_hi;
  logic [BITWIDTH-1:0] res_data;
  logic                res_over;

  logic                s2_free;
  logic                s1_adv;
  logic                accept;

  assign lo_full   = {1'b0, iSum[LOW_W-1:0]} - {1'b0, iData0[LOW_W-1:0]};
  assign hi_full   = {1'b0, sum_hi} - {2'b00, data0_hi} - {{HI_W{1'b0}}, borrow_lo};
  assign borrow_hi = hi_full[HI_W];
  assign diff_hi   = hi_full[HI_W-1:0];
  assign res_over  = ~borrow_hi & diff_hi[HI_W-1];

  always_comb begin
    res_data = {diff_hi[HI_W-2:0], diff_lo};
`ifdef ADDER_INV_SATURATE_EN
    if (borrow_hi) begin
      res_data = '0;
    end else if (res_over) begin
      res_data = '1;
    end
`endif
  end

  // s2 can take a new beat when empty or when its current beat leaves this edge
  assign s2_free = ~oValid | iReady;
  assign s1_adv  = s1_valid & s2_free;
  assign oReady  = rst_done & (~s1_valid | s1_adv);
  assign accept  = iValid & oReady;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      s1_valid  <= 1'b0;
      diff_lo   <= '0;
      borrow_lo <= 1'b0;
      sum_hi    <= '0;
      data0_hi  <= '0;
    end else if (iClr) begin
      s1_valid  <= 1'b0;
      diff_lo   <= '0;
      borrow_lo <= 1'b0;
      sum_hi    <= '0;
      data0_hi  <= '0;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      diff_lo   <= lo_full[LOW_W-1:0];
      borrow_lo <= lo_full[LOW_W];
      sum_hi    <= iSum[BITWIDTH:LOW_W];
      data0_hi  <= iData0[BITWIDTH-1:LOW_W];
    end else if (s1_adv) begin
      s1_valid  <= 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oValid     <= 1'b0;
      oData      <= '0;
      oUnderflow <= 1'b0;
      oOverflow  <= 1'b0;
    end else if (iClr) begin
      oValid     <= 1'b0;
      oData      <= '0;
      oUnderflow <= 1'b0;
      oOverflow  <= 1'b0;
    end else if (s1_adv) begin
      oValid     <= 1'b1;
      oData      <= res_data;
      oUnderflow <= borrow_hi;
      oOverflow  <= res_over;
    end else if (iReady) begin
      oValid     <= 1'b0;
    end
  end

endmodule
